// File: rtl/seg_pkg.sv
// Shared segment types and the active-low hex glyph table for the scan controller.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Entry n is the glyph for nibble n, bit order {a,b,c,d,e,f,g}, 0 = segment lit.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h38, 7'h30, 7'h42, 7'h31,   // F E d C
    7'h60, 7'h08, 7'h04, 7'h00,   // b A 9 8
    7'h0F, 7'h20, 7'h24, 7'h4C,   // 7 6 5 4
    7'h06, 7'h12, 7'h4F, 7'h01    // 3 2 1 0
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Value-load and display-pin bundle between system logic, the scan controller and the board.
interface seg_scan_ctrl_if
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8
);

  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     en_mask;
  logic                      blank_lz;

  logic [NUM_DIGITS-1:0]     an;
  seg_t                      seg;
  logic                      dp;
  logic                      pending;
  logic                      load_ack;
  logic                      frame_done;

  modport master (
    output load, value, dp_in, en_mask, blank_lz,
    input  an, seg, dp, pending, load_ack, frame_done
  );

  modport slave (
    input  load, value, dp_in, en_mask, blank_lz,
    output an, seg, dp, pending, load_ack, frame_done
  );

endinterface

// File: rtl/hex7_decoder.sv
// Combinational nibble to active-low seven-segment pattern.
module hex7_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg_c
);

  assign seg_c = HEX_GLYPH[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: double-buffered value, one digit lit per refresh slot,
// leading-zero blanking and per-digit enable mask, all pin outputs registered.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000
)(
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned TICK_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned VAL_W  = 4 * NUM_DIGITS;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [TICK_W-1:0]     tick_q, tick_n;
  logic [IDX_W-1:0]      idx_q, idx_n;
  logic [VAL_W-1:0]      shadow_val_q, shadow_val_n;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_n;
  logic [VAL_W-1:0]      active_val_q, active_val_n;
  logic [NUM_DIGITS-1:0] active_dp_q, active_dp_n;
  logic                  pending_q, pending_n;
  logic                  frame_done_q, frame_done_n;
  logic                  load_ack_q, load_ack_n;
  logic                  wrap;

  logic [NUM_DIGITS-1:0] an_q, an_n;
  seg_t                  seg_q, seg_n;
  logic                  dp_q, dp_n;

  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  lz_run;
  logic                  lit;
  logic [3:0]            nib;
  seg_t                  glyph_c;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q       <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      load_ack_q   <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      tick_q       <= tick_n;
      idx_q        <= idx_n;
      shadow_val_q <= shadow_val_n;
      shadow_dp_q  <= shadow_dp_n;
      active_val_q <= active_val_n;
      active_dp_q  <= active_dp_n;
      pending_q    <= pending_n;
      frame_done_q <= frame_done_n;
      load_ack_q   <= load_ack_n;
      an_q         <= an_n;
      seg_q        <= seg_n;
      dp_q         <= dp_n;
    end
  end

  // Scan sequencing and buffer commit; a load on the commit cycle lands in the shadow after it.
  always_comb begin
    tick_n       = tick_q + TICK_W'(1);
    idx_n        = idx_q;
    shadow_val_n = shadow_val_q;
    shadow_dp_n  = shadow_dp_q;
    active_val_n = active_val_q;
    active_dp_n  = active_dp_q;
    pending_n    = pending_q;
    wrap         = (tick_q == TICK_LAST) && (idx_q == IDX_LAST);

    if (tick_q == TICK_LAST) begin
      tick_n = '0;
      idx_n  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    if (wrap && pending_q) begin
      active_val_n = shadow_val_q;
      active_dp_n  = shadow_dp_q;
      pending_n    = 1'b0;
    end

    if (bus.load) begin
      shadow_val_n = bus.value;
      shadow_dp_n  = bus.dp_in;
      pending_n    = 1'b1;
    end

    // Registered strobes line up with the cycle in which the next state sits on the wrap point.
    frame_done_n = (tick_n == TICK_LAST) && (idx_n == IDX_LAST);
    load_ack_n   = frame_done_n && pending_n;
  end

  assign nib = active_val_q[{idx_q, 2'b00} +: 4];

  hex7_decoder u_dec (
    .nib   (nib),
    .seg_c (glyph_c)
  );

  // Pin pattern for the current digit: leading-zero run from the top, enable mask, glyph.
  always_comb begin
    lz_blank = '0;
    lz_run   = bus.blank_lz;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run      = lz_run && (active_val_q[4*i +: 4] == 4'h0);
      lz_blank[i] = lz_run;
    end

    lit   = bus.en_mask[idx_q] && !lz_blank[idx_q];
    an_n  = '1;
    seg_n = SEG_BLANK;
    dp_n  = 1'b1;
    if (lit) begin
      an_n[idx_q] = 1'b0;
      seg_n       = glyph_c;
      dp_n        = ~active_dp_q[idx_q];
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.pending    = pending_q;
  assign bus.load_ack   = load_ack_q;
  assign bus.frame_done = frame_done_q;

endmodule
